// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART transmit path: frame state encoding,
// default payload width and parity-type constants. The parity constants
// are shared with the RX parity check so both ends agree on polarity.
package uart_tx_pkg;

    // Default payload width of one frame
    localparam int UART_DATA_WIDTH = 8;

    // Parity type selector values (PAR_TYP input)
    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    // Transmit frame states, in the order the line walks through them
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_e;

endpackage

// File: rtl/uart_tx_if.sv
// Parallel-side interface of the UART transmitter: byte, load strobe,
// parity controls, plus the serial line and busy flag coming back.
interface uart_tx_if import uart_tx_pkg::*; #(
    parameter int DATA_WIDTH = UART_DATA_WIDTH
);

    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  DATA_VALID;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic                  TX_OUT;
    logic                  Busy;

    // Register/FIFO read side that feeds bytes into the transmitter
    modport master (
        output P_DATA,
        output DATA_VALID,
        output PAR_EN,
        output PAR_TYP,
        input  TX_OUT,
        input  Busy
    );

    // The transmitter itself
    modport slave (
        input  P_DATA,
        input  DATA_VALID,
        input  PAR_EN,
        input  PAR_TYP,
        output TX_OUT,
        output Busy
    );

endinterface

// File: rtl/uart_tx_parity_calc.sv
// Parity bit generator for the transmitter. Same definition as the RX
// checker: even parity sends the XOR of the data, odd sends its inverse.
module uart_tx_parity_calc import uart_tx_pkg::*; #(
    parameter int DATA_WIDTH = UART_DATA_WIDTH
) (
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  par_typ,
    output logic                  parity
);

    // Select the parity polarity from the latched parity type
    always_comb begin
        parity = ^data;
        case (par_typ)
            PAR_EVEN: parity = ^data;
            PAR_ODD:  parity = ~(^data);
            default:  parity = ^data;
        endcase
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmit serializer. Latches a byte on a one-cycle strobe while
// idle and sends start bit, data LSB first, optional parity, stop bit,
// one bit per CLK. TX_OUT and Busy come straight from flops.
module uart_tx import uart_tx_pkg::*; #(
    parameter int DATA_WIDTH = UART_DATA_WIDTH
) (
    input  logic       CLK,
    input  logic       RESET,
    uart_tx_if.slave   bus
);

    localparam int              CNT_W    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

    tx_state_e              state;
    tx_state_e              state_d;
    logic [CNT_W-1:0]       bit_cnt;
    logic [CNT_W-1:0]       bit_cnt_d;
    logic [DATA_WIDTH-1:0]  tx_data;
    logic                   par_en_q;
    logic                   par_typ_q;
    logic                   load;
    logic                   tx_q;
    logic                   tx_d;
    logic                   busy_q;
    logic                   busy_d;
    logic                   parity;

    uart_tx_parity_calc #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_parity (
        .data    (tx_data),
        .par_typ (par_typ_q),
        .parity  (parity)
    );

    // Next state plus the value TX_OUT/Busy must show during that state
    always_comb begin
        state_d   = state;
        bit_cnt_d = bit_cnt;
        tx_d      = 1'b1;
        busy_d    = 1'b1;
        load      = 1'b0;
        case (state)
            IDLE: begin
                busy_d    = 1'b0;
                bit_cnt_d = '0;
                if (bus.DATA_VALID) begin
                    load    = 1'b1;
                    state_d = START;
                    tx_d    = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            START: begin
                state_d   = DATA;
                bit_cnt_d = '0;
                tx_d      = tx_data[0];
            end
            DATA: begin
                if (bit_cnt == CNT_LAST) begin
                    if (par_en_q) begin
                        state_d = PARITY;
                        tx_d    = parity;
                    end else begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end
                end else begin
                    bit_cnt_d = bit_cnt + 1'b1;
                    tx_d      = tx_data[bit_cnt_d];
                end
            end
            PARITY: begin
                state_d = STOP;
                tx_d    = 1'b1;
            end
            STOP: begin
                state_d   = IDLE;
                bit_cnt_d = '0;
                tx_d      = 1'b1;
                busy_d    = 1'b0;
            end
            default: begin
                state_d   = IDLE;
                bit_cnt_d = '0;
                tx_d      = 1'b1;
                busy_d    = 1'b0;
            end
        endcase
    end

    // State, bit counter and registered line outputs
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state   <= IDLE;
            bit_cnt <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state   <= state_d;
            bit_cnt <= bit_cnt_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
        end
    end

    // Capture byte and parity controls once per frame so later input changes are ignored
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            tx_data   <= '0;
            par_en_q  <= 1'b0;
            par_typ_q <= PAR_EVEN;
        end else if (load) begin
            tx_data   <= bus.P_DATA;
            par_en_q  <= bus.PAR_EN;
            par_typ_q <= bus.PAR_TYP;
        end
    end

    assign bus.TX_OUT = tx_q;
    assign bus.Busy   = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: stimulus pushes the hand-written frame
// each load should produce; the monitor collects every Busy window off
// the line and compares it with the head of the queue.
module tb_uart_tx;

    localparam int DW = 8;

    typedef struct {
        logic [15:0] seq;
        int          len;
        int          gap;
        bit          abort;
    } exp_t;

    logic CLK = 1'b0;
    logic RESET;

    uart_tx_if #(.DATA_WIDTH(DW)) bus ();

    uart_tx #(.DATA_WIDTH(DW)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    exp_t        exp_q[$];
    exp_t        cur;
    int          num_checks = 0;
    int          num_fails  = 0;
    bit          capturing  = 1'b0;
    bit          gap_known  = 1'b0;
    logic [15:0] mon_seq    = '0;
    int          mon_len    = 0;
    int          idle_cnt   = 0;

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        num_checks++;
        if (actual !== expected) begin
            num_fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] data, input logic pe, input logic pt,
                                 input logic [15:0] seq, input int len, input int gap, input bit abort);
        exp_t e;
        e.seq   = seq;
        e.len   = len;
        e.gap   = gap;
        e.abort = abort;
        exp_q.push_back(e);
        @(negedge CLK);
        bus.P_DATA     = data;
        bus.PAR_EN     = pe;
        bus.PAR_TYP    = pt;
        bus.DATA_VALID = 1'b1;
        @(negedge CLK);
        bus.DATA_VALID = 1'b0;
    endtask

    task automatic waitIdle();
        int n = 0;
        while ((exp_q.size() != 0 || capturing || bus.Busy) && n < 200) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 200) begin
            num_checks++;
            num_fails++;
            $display("[TB] FAIL wait_idle: still busy after %0d cycles, expected idle", n);
        end
        repeat (3) @(negedge CLK);
    endtask

    // Monitor: collect each Busy window and score it against the queue head
    always @(negedge CLK) begin
        if (RESET) begin
            if (capturing) begin
                checkOutput("abort_expected", {15'd0, cur.abort}, 16'd1);
                capturing = 1'b0;
            end
            gap_known = 1'b0;
        end else if (bus.Busy) begin
            if (!capturing) begin
                capturing = 1'b1;
                mon_seq   = '0;
                mon_len   = 0;
                if (exp_q.size() == 0) begin
                    num_checks++;
                    num_fails++;
                    $display("[TB] FAIL unexpected_frame: frame started, expected none (t=%0t)", $time);
                    cur = '{seq: 16'd0, len: 0, gap: -1, abort: 1'b0};
                end else begin
                    cur = exp_q.pop_front();
                end
                if (cur.gap >= 0 && gap_known)
                    checkOutput("idle_gap", 16'(idle_cnt), 16'(cur.gap));
            end
            mon_seq = {mon_seq[14:0], bus.TX_OUT};
            mon_len++;
        end else begin
            if (capturing) begin
                capturing = 1'b0;
                if (cur.abort) begin
                    num_checks++;
                    num_fails++;
                    $display("[TB] FAIL frame_not_aborted: frame completed, expected abort by reset");
                end else begin
                    checkOutput("frame_len", 16'(mon_len), 16'(cur.len));
                    checkOutput("frame_bits", mon_seq, cur.seq);
                end
                idle_cnt  = 0;
                gap_known = 1'b1;
            end
            idle_cnt++;
            checkOutput("idle_line_high", {15'd0, bus.TX_OUT}, 16'd1);
        end
    end

    // Hard stop in case the stimulus itself stalls
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed test sequence
    initial begin
        RESET          = 1'b1;
        bus.P_DATA     = '0;
        bus.DATA_VALID = 1'b0;
        bus.PAR_EN     = 1'b0;
        bus.PAR_TYP    = 1'b0;
        #1;
        checkOutput("reset_tx_out", {15'd0, bus.TX_OUT}, 16'd1);
        checkOutput("reset_busy",   {15'd0, bus.Busy},   16'd0);
        repeat (2) @(negedge CLK);
        #2 RESET = 1'b0;
        repeat (2) @(negedge CLK);

        $display("[TB] 0xA5 without parity");
        applyStimulus(8'hA5, 1'b0, 1'b0, 16'b0101001011, 10, -1, 1'b0);
        waitIdle();

        $display("[TB] 0xA5 with even and odd parity");
        applyStimulus(8'hA5, 1'b1, 1'b0, 16'b01010010101, 11, -1, 1'b0);
        waitIdle();
        applyStimulus(8'hA5, 1'b1, 1'b1, 16'b01010010111, 11, -1, 1'b0);
        waitIdle();

        $display("[TB] 0x07 with even and odd parity");
        applyStimulus(8'h07, 1'b1, 1'b0, 16'b01110000011, 11, -1, 1'b0);
        waitIdle();
        applyStimulus(8'h07, 1'b1, 1'b1, 16'b01110000001, 11, -1, 1'b0);
        waitIdle();

        $display("[TB] 0xFF with mid-frame input changes");
        applyStimulus(8'hFF, 1'b1, 1'b0, 16'b01111111101, 11, -1, 1'b0);
        repeat (3) @(negedge CLK);
        checkOutput("mid_frame_busy", {15'd0, bus.Busy}, 16'd1);
        bus.P_DATA     = 8'h00;
        bus.PAR_TYP    = 1'b1;
        bus.DATA_VALID = 1'b1;
        @(negedge CLK);
        bus.DATA_VALID = 1'b0;
        waitIdle();
        repeat (15) @(negedge CLK);
        bus.PAR_TYP = 1'b0;

        $display("[TB] 0x3C with DATA_VALID held high");
        begin
            exp_t e;
            e = '{seq: 16'b0001111001, len: 10, gap: -1, abort: 1'b0};
            exp_q.push_back(e);
            e.gap = 1;
            exp_q.push_back(e);
            exp_q.push_back(e);
        end
        @(negedge CLK);
        bus.P_DATA     = 8'h3C;
        bus.PAR_EN     = 1'b0;
        bus.DATA_VALID = 1'b1;
        repeat (23) @(negedge CLK);
        bus.DATA_VALID = 1'b0;
        waitIdle();

        $display("[TB] reset during 0x55 frame, then 0x81");
        applyStimulus(8'h55, 1'b0, 1'b0, 16'd0, 0, -1, 1'b1);
        repeat (5) @(negedge CLK);
        checkOutput("pre_reset_busy",   {15'd0, bus.Busy},   16'd1);
        checkOutput("pre_reset_tx_out", {15'd0, bus.TX_OUT}, 16'd1);
        #2 RESET = 1'b1;
        #1;
        checkOutput("mid_reset_tx_out", {15'd0, bus.TX_OUT}, 16'd1);
        checkOutput("mid_reset_busy",   {15'd0, bus.Busy},   16'd0);
        repeat (2) @(negedge CLK);
        #2 RESET = 1'b0;
        applyStimulus(8'h81, 1'b0, 1'b0, 16'b0100000011, 10, -1, 1'b0);
        waitIdle();

        checkOutput("queue_drained", 16'(exp_q.size()), 16'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
UART transmit serializer: the transmit-side counterpart of the RX parity check, on the same frame format. Accepts a parallel byte on a one-cycle valid strobe and shifts out one frame. Frame order is start bit, DATA_WIDTH data bits LSB first, optional parity bit, stop bit. One bit per CLK cycle; CLK is the TX bit clock from the system clock divider. Sits between the system register/FIFO read side and the TX_OUT pin.

Parameters:
DATA_WIDTH, 8, payload bits per frame

Ports:
CLK  input  1  TX bit clock; all state on rising edge
RESET  input  1  asynchronous, active-high reset
P_DATA  input  DATA_WIDTH  parallel byte to send
DATA_VALID  input  1  load strobe; sampled only in IDLE
PAR_EN  input  1  1 = insert parity bit
PAR_TYP  input  1  0 = even parity, 1 = odd parity
TX_OUT  output  1  serial line; idles high
Busy  output  1  high while a frame is in flight

Behaviour:
- Reset (async, immediate, also mid-frame):
  - state IDLE, bit counter 0, shift register 0.
  - TX_OUT = 1, Busy = 0.
  - Any partial frame is abandoned; the line returns high at once.
- All outputs are registered; no combinational path from inputs to TX_OUT or Busy.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - TX_OUT = 1, Busy = 0.
  - On an edge with DATA_VALID = 1, latch P_DATA, PAR_EN and PAR_TYP into internal registers.
  - On that same edge go to START, set TX_OUT <= 0 and Busy <= 1.
  - The start bit appears the cycle after DATA_VALID is sampled.
- START: 1 cycle, TX_OUT = 0, then DATA with counter 0.
- DATA:
  - DATA_WIDTH cycles; TX_OUT = latched_data[counter], LSB first.
  - Counter increments each cycle.
  - At counter = DATA_WIDTH-1, go to PARITY if latched PAR_EN = 1, else STOP.
- PARITY:
  - 1 cycle, TX_OUT = (^latched_data) XOR latched PAR_TYP.
  - Even parity: bit = XOR of data. Odd parity: bit = inverted XOR. This matches the RX checker.
- STOP:
  - 1 cycle, TX_OUT = 1, Busy stays 1.
  - Next edge: IDLE, Busy <= 0, TX_OUT stays 1.
- Frame length from first start-bit cycle through the stop bit:
  - DATA_WIDTH+2 cycles without parity (10 at default).
  - DATA_WIDTH+3 cycles with parity (11 at default).
  - Busy is high exactly for those cycles.
- Back-to-back frames:
  - DATA_VALID is ignored in every state except IDLE; the strobe is not queued.
  - Minimum one IDLE cycle (line high) between frames.
  - DATA_VALID held high through IDLE starts the next frame on the first IDLE edge.
- Changes to P_DATA, PAR_EN or PAR_TYP while Busy = 1 have no effect on the current frame.
- Counter width: $clog2(DATA_WIDTH); no wrap beyond DATA_WIDTH-1.
- Illegal state encodings return to IDLE with TX_OUT = 1.

Decomposition:
- Shared package holds:
  - state encoding constants (IDLE, START, DATA, PARITY, STOP);
  - the default DATA_WIDTH;
  - parity-type constants PAR_EVEN = 0, PAR_ODD = 1. These are shared with the RX parity check.
- One sub-module, uart_tx_parity_calc:
  - combinational; takes latched data and PAR_TYP, outputs the parity bit;
  - mirrors the RX checker so both ends use one definition.
- The FSM, counter, latch and output mux stay in uart_tx.

Test Plan:
1. P_DATA = 0xA5, PAR_EN = 0, one-cycle DATA_VALID -> TX_OUT = 0,1,0,1,0,0,1,0,1,1 over 10 cycles; Busy high exactly 10 cycles, then TX_OUT = 1, Busy = 0.
2. P_DATA = 0xA5, PAR_EN = 1, PAR_TYP = 0 -> parity bit 0, 11-cycle frame; with PAR_TYP = 1 -> parity bit 1.
3. P_DATA = 0x07, PAR_EN = 1 -> even parity bit 1, odd parity bit 0; data bits 1,1,1,0,0,0,0,0.
4. Start 0xFF; during the 3rd data bit pulse DATA_VALID with P_DATA = 0x00 and flip PAR_TYP -> current frame completes unchanged as 0xFF with the original parity; the second strobe is dropped.
5. DATA_VALID held high continuously with P_DATA = 0x3C, no parity -> repeated 10-cycle frames, each separated by exactly one idle-high cycle.
6. Assert RESET during the 5th data bit of a 0x55 frame -> TX_OUT = 1 and Busy = 0 immediately. After release, the next DATA_VALID with 0x81 produces a clean frame 0,1,0,0,0,0,0,0,1,1.
